// File: rtl/mbldcm_commutation_sequencer.sv
// Six-step BLDC commutation sequencer: shared phase index 0..5, blanking strobe and step pulse.
// Define MBLDCM_COMMUTATION_SEQUENCER_DEADTIME_EN to build the DEAD state and dead-time counter.
module mbldcm_commutation_sequencer #(
  parameter int pPeriodWidth = 16,
  parameter int pDeadWidth   = 8
) (
  input  logic                    iClk,
  input  logic                    iRst,
  input  logic                    iEnable,
  input  logic                    iDirection,
  input  logic [pPeriodWidth-1:0] iPeriod,
  input  logic [pDeadWidth-1:0]   iDeadTime,
  output logic [2:0]              oPhase,
  output logic                    oBlank,
  output logic                    oStepPulse,
  output logic                    oRunning,
  output logic [1:0]              oState
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DEAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  localparam logic [pPeriodWidth-1:0] PERIOD_ONE = pPeriodWidth'(1);

  state_t                  state_q, state_d, entry_state;
  logic [pPeriodWidth-1:0] step_cnt_q, step_cnt_d;
  logic [2:0]              phase_q, phase_d, phase_adv;
  logic                    pulse_q, pulse_d, step_due;

`ifdef MBLDCM_COMMUTATION_SEQUENCER_DEADTIME_EN
  localparam logic [pDeadWidth-1:0] DEAD_ONE = pDeadWidth'(1);
  logic [pDeadWidth-1:0] dead_cnt_q, dead_cnt_d;
  // A zero dead time skips blanking entirely and goes straight to RUN.
  assign entry_state = (iDeadTime != '0) ? ST_DEAD : ST_RUN;
`else
  logic unused_dead_time;
  assign unused_dead_time = ^iDeadTime;
  assign entry_state      = ST_RUN;
`endif

  // Live compare against iPeriod; >= lets a shortened period step on the next edge.
  assign step_due = (iPeriod != '0) && (step_cnt_q >= iPeriod - PERIOD_ONE);

  always_comb begin
    phase_adv = phase_q;
    if (iDirection) phase_adv = (phase_q == 3'd0) ? 3'd5 : phase_q - 3'd1;
    else            phase_adv = (phase_q == 3'd5) ? 3'd0 : phase_q + 3'd1;
  end

  always_comb begin
    state_d    = state_q;
    step_cnt_d = step_cnt_q;
    phase_d    = phase_q;
    pulse_d    = 1'b0;
`ifdef MBLDCM_COMMUTATION_SEQUENCER_DEADTIME_EN
    dead_cnt_d = dead_cnt_q;
`endif
    if (!iEnable) begin
      state_d    = ST_IDLE;
      step_cnt_d = '0;
`ifdef MBLDCM_COMMUTATION_SEQUENCER_DEADTIME_EN
      dead_cnt_d = '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d    = entry_state;
          step_cnt_d = '0;
`ifdef MBLDCM_COMMUTATION_SEQUENCER_DEADTIME_EN
          dead_cnt_d = iDeadTime;
`endif
        end
`ifdef MBLDCM_COMMUTATION_SEQUENCER_DEADTIME_EN
        ST_DEAD: begin
          if (dead_cnt_q <= DEAD_ONE) begin
            state_d    = ST_RUN;
            dead_cnt_d = '0;
            step_cnt_d = '0;
          end else begin
            dead_cnt_d = dead_cnt_q - DEAD_ONE;
          end
        end
`endif
        ST_RUN: begin
          if (step_due) begin
            phase_d    = phase_adv;
            pulse_d    = 1'b1;
            step_cnt_d = '0;
            state_d    = entry_state;
`ifdef MBLDCM_COMMUTATION_SEQUENCER_DEADTIME_EN
            dead_cnt_d = iDeadTime;
`endif
          end else begin
            step_cnt_d = step_cnt_q + PERIOD_ONE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q    <= ST_IDLE;
      step_cnt_q <= '0;
      phase_q    <= 3'd0;
      pulse_q    <= 1'b0;
`ifdef MBLDCM_COMMUTATION_SEQUENCER_DEADTIME_EN
      dead_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      step_cnt_q <= step_cnt_d;
      phase_q    <= phase_d;
      pulse_q    <= pulse_d;
`ifdef MBLDCM_COMMUTATION_SEQUENCER_DEADTIME_EN
      dead_cnt_q <= dead_cnt_d;
`endif
    end
  end

  // Blank and running decode straight from the state register, so the new
  // phase and the rising blank appear on the same edge.
  assign oPhase     = phase_q;
  assign oBlank     = (state_q != ST_RUN);
  assign oRunning   = (state_q != ST_IDLE);
  assign oStepPulse = pulse_q;
  assign oState     = state_q;

endmodule
